// File: rtl/blinker_pkg.sv
// Shared types and helpers for the LED-pattern ramp monitor.
// Holds the tracker FSM state encoding and the thermometer-code decoder.
package blinker_pkg;

    localparam int unsigned THERM_MAX_WIDTH = 32;
    localparam int unsigned THERM_LEVEL_W   = 6;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        TRACK      = 1'b1
    } state_t;

    typedef struct packed {
        logic                     valid;
        logic [THERM_LEVEL_W-1:0] level;
    } therm_t;

    // A valid thermometer code is a contiguous run of ones starting at bit 0,
    // which is exactly when code & (code + 1) has no bits set.
    function automatic therm_t therm_decode(input logic [THERM_MAX_WIDTH-1:0] code);
        therm_t                     r;
        logic [THERM_MAX_WIDTH-1:0] plus1;
        plus1   = code + THERM_MAX_WIDTH'(1);
        r.valid = ((code & plus1) == '0);
        r.level = '0;
        for (int unsigned i = 0; i < THERM_MAX_WIDTH; i++) begin
            r.level = r.level + THERM_LEVEL_W'(code[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/stable_filter.sv
// Two-flop synchronizer followed by a run-length stability filter.
// new_stable strobes combinationally on the edge where the run reaches STABLE_CYCLES.
module stable_filter
    import blinker_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] stable_value,
    output logic             new_stable
);

    localparam int unsigned     RW      = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0]   RUN_MAX = RW'(STABLE_CYCLES);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] candidate;
    logic [RW-1:0]    run;
    logic [RW-1:0]    run_next;
    logic             differs;

    always_comb begin
        differs = (sync2 != candidate);
        if (differs) begin
            run_next = RW'(1);
        end else if (run == RUN_MAX) begin
            run_next = RUN_MAX;
        end else begin
            run_next = run + RW'(1);
        end
    end

    // A saturated run with an unchanged sample has already been reported once.
    assign new_stable   = (run_next == RUN_MAX) && ((run != RUN_MAX) || differs);
    assign stable_value = sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            candidate <= '0;
            run       <= '0;
        end else begin
            sync1     <= in;
            sync2     <= sync1;
            candidate <= sync2;
            run       <= run_next;
        end
    end

endmodule

// File: rtl/ramp_monitor.sv
// Tracks a thermometer-coded LED ramp: decodes stable levels, reports single steps,
// direction reversals and a sticky error for invalid codes or multi-level jumps.
module ramp_monitor
    import blinker_pkg::*;
#(
    parameter int unsigned WIDTH            = 4,
    parameter int unsigned STABLE_CYCLES    = 4,
    parameter int unsigned STEP_COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in,
    output logic [$clog2(WIDTH+1)-1:0]    level,
    output logic                          level_valid,
    output logic                          dir_up,
    output logic                          step_pulse,
    output logic                          reverse_pulse,
    output logic                          err,
    output logic [STEP_COUNT_WIDTH-1:0]   step_count
);

    localparam int unsigned LW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] stable_value;
    logic             new_stable;
    therm_t           dec;
    logic [LW-1:0]    new_level;
    logic             step_up;
    logic             step_dn;
    logic             have_step;
    state_t           state;

    stable_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk          (clk),
        .rst          (rst),
        .in           (in),
        .stable_value (stable_value),
        .new_stable   (new_stable)
    );

    always_comb begin
        dec       = therm_decode(THERM_MAX_WIDTH'(stable_value));
        new_level = LW'(dec.level);
        step_up   = ({1'b0, new_level} == ({1'b0, level} + {{LW{1'b0}}, 1'b1}));
        step_dn   = ({1'b0, level} == ({1'b0, new_level} + {{LW{1'b0}}, 1'b1}));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WAIT_FIRST;
            level         <= '0;
            level_valid   <= 1'b0;
            dir_up        <= 1'b0;
            step_pulse    <= 1'b0;
            reverse_pulse <= 1'b0;
            err           <= 1'b0;
            step_count    <= '0;
            have_step     <= 1'b0;
        end else begin
            step_pulse    <= 1'b0;
            reverse_pulse <= 1'b0;
            if (new_stable) begin
                if (!dec.valid) begin
                    err <= 1'b1;
                end else begin
                    case (state)
                        WAIT_FIRST: begin
                            level       <= new_level;
                            level_valid <= 1'b1;
                            state       <= TRACK;
                        end
                        TRACK: begin
                            if (step_up || step_dn) begin
                                level      <= new_level;
                                dir_up     <= step_up;
                                step_pulse <= 1'b1;
                                step_count <= step_count + STEP_COUNT_WIDTH'(1);
                                have_step  <= 1'b1;
                                // dir_up is only meaningful once a step has set it
                                if (have_step && (step_up != dir_up)) begin
                                    reverse_pulse <= 1'b1;
                                end
                            end else if (new_level != level) begin
                                err   <= 1'b1;
                                level <= new_level;
                            end
                        end
                        default: state <= WAIT_FIRST;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ramp_monitor.sv
// Self-checking bench for ramp_monitor: directed vector table, hand-written corner
// sequences, then randomized segments checked against an acceptance-level model.
module tb_ramp_monitor;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned STABLE = 4;
    localparam int unsigned SCW    = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in;
    logic [2:0]       level;
    logic             level_valid;
    logic             dir_up;
    logic             step_pulse;
    logic             reverse_pulse;
    logic             err;
    logic [SCW-1:0]   step_count;

    ramp_monitor #(
        .WIDTH            (WIDTH),
        .STABLE_CYCLES    (STABLE),
        .STEP_COUNT_WIDTH (SCW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in            (in),
        .level         (level),
        .level_valid   (level_valid),
        .dir_up        (dir_up),
        .step_pulse    (step_pulse),
        .reverse_pulse (reverse_pulse),
        .err           (err),
        .step_count    (step_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int step_seen = 0;
    int rev_seen  = 0;
    int lone_rev  = 0;

    always @(posedge clk) begin
        #1;
        if (step_pulse === 1'b1) step_seen++;
        if (reverse_pulse === 1'b1) begin
            rev_seen++;
            if (step_pulse !== 1'b1) lone_rev++;
        end
    end

    typedef struct {
        logic [3:0] code;
        int         hold;
        int         lvl;
        bit         valid;
        bit         dir;
        bit         er;
        int         cnt;
        int         steps;
        int         revs;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int lvl, input bit valid, input bit dir,
                            input bit er, input int cnt);
        chk({tag, ".level"}, 32'(level), 32'(lvl));
        chk({tag, ".level_valid"}, 32'(level_valid), 32'(valid));
        chk({tag, ".dir_up"}, 32'(dir_up), 32'(dir));
        chk({tag, ".err"}, 32'(err), 32'(er));
        chk({tag, ".step_count"}, 32'(step_count), 32'(cnt));
    endtask

    task automatic apply_row(input int i);
        int    bs;
        int    br;
        string tag;
        tag = $sformatf("row%0d", i);
        bs  = step_seen;
        br  = rev_seen;
        @(negedge clk);
        in = vecs[i].code;
        repeat (vecs[i].hold) @(negedge clk);
        chk_outs(tag, vecs[i].lvl, vecs[i].valid, vecs[i].dir, vecs[i].er, vecs[i].cnt);
        chk({tag, ".steps"}, 32'(step_seen - bs), 32'(vecs[i].steps));
        chk({tag, ".revs"}, 32'(rev_seen - br), 32'(vecs[i].revs));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_outs(tag, 0, 1'b0, 1'b0, 1'b0, 0);
        chk({tag, ".step_pulse"}, 32'(step_pulse), 32'd0);
        chk({tag, ".reverse_pulse"}, 32'(reverse_pulse), 32'd0);
        rst = 1'b0;
    endtask

    // Acceptance-level reference: each sufficiently long input segment is one event.
    int m_level, m_cnt, m_steps, m_revs;
    bit m_valid, m_dir, m_err, m_have;

    task automatic model_reset();
        m_level = 0; m_cnt = 0; m_steps = 0; m_revs = 0;
        m_valid = 0; m_dir = 0; m_err = 0; m_have = 0;
    endtask

    task automatic model_accept(input logic [3:0] v);
        int iv;
        int lv;
        bit up;
        iv = int'(v);
        lv = $countones(v);
        if ((iv & (iv + 1)) != 0) begin
            m_err = 1;
        end else if (!m_valid) begin
            m_valid = 1;
            m_level = lv;
        end else if (lv == m_level + 1 || lv == m_level - 1) begin
            up = (lv > m_level);
            if (m_have && up != m_dir) m_revs++;
            m_dir   = up;
            m_cnt   = (m_cnt + 1) % (1 << SCW);
            m_have  = 1;
            m_steps++;
            m_level = lv;
        end else if (lv != m_level) begin
            m_err   = 1;
            m_level = lv;
        end
    endtask

    initial begin
        int first_edge;
        int bs, br;
        logic [3:0] prev;
        logic [3:0] v;

        //          code     hold lvl val dir er cnt st rv
        vecs[0]  = '{4'b0000, 10, 0, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{4'b0001,  8, 1, 1, 1, 0, 1, 1, 0};
        vecs[2]  = '{4'b0011,  8, 2, 1, 1, 0, 2, 1, 0};
        vecs[3]  = '{4'b0111,  8, 3, 1, 1, 0, 3, 1, 0};
        vecs[4]  = '{4'b1111,  8, 4, 1, 1, 0, 4, 1, 0};
        vecs[5]  = '{4'b0111,  8, 3, 1, 0, 0, 5, 1, 1};
        vecs[6]  = '{4'b0101,  8, 2, 1, 0, 1, 6, 0, 0};
        vecs[7]  = '{4'b0001,  8, 1, 1, 0, 1, 7, 1, 0};
        vecs[8]  = '{4'b1111,  8, 4, 1, 0, 1, 7, 0, 0};
        vecs[9]  = '{4'b0111,  8, 3, 1, 0, 1, 8, 1, 0};
        vecs[10] = '{4'b0111, 10, 3, 1, 0, 0, 0, 0, 0};
        vecs[11] = '{4'b1111,  8, 4, 1, 1, 0, 1, 1, 0};
        vecs[12] = '{4'b0111,  8, 3, 1, 0, 0, 2, 1, 1};
        vecs[13] = '{4'b0011,  8, 2, 1, 0, 0, 3, 1, 0};
        vecs[14] = '{4'b0001,  8, 1, 1, 0, 0, 4, 1, 0};
        vecs[15] = '{4'b0000,  8, 0, 1, 0, 0, 5, 1, 0};
        vecs[16] = '{4'b0001,  8, 1, 1, 1, 0, 6, 1, 1};

        rst = 1'b1;
        in  = '0;
        do_reset("reset0");

        for (int i = 0; i <= 5; i++) apply_row(i);

        // 3 -> 2: step must appear on exactly the sixth rising edge after the change
        first_edge = 0;
        @(negedge clk);
        in = 4'b0011;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            if (step_pulse === 1'b1 && first_edge == 0) first_edge = e;
        end
        chk("latency.edges", 32'(first_edge), 32'(STABLE + 2));
        @(negedge clk);
        chk_outs("latency", 2, 1'b1, 1'b0, 1'b0, 6);

        // two-cycle glitch is shorter than the stability window
        bs = step_seen;
        br = rev_seen;
        @(negedge clk);
        in = 4'b0111;
        repeat (2) @(negedge clk);
        in = 4'b0011;
        repeat (10) @(negedge clk);
        chk_outs("glitch", 2, 1'b1, 1'b0, 1'b0, 6);
        chk("glitch.steps", 32'(step_seen - bs), 32'd0);
        chk("glitch.revs", 32'(rev_seen - br), 32'd0);

        for (int i = 6; i <= 9; i++) apply_row(i);

        do_reset("reset_mid");
        for (int i = 10; i <= 16; i++) apply_row(i);

        in = '0;
        do_reset("reset_rand");
        model_reset();
        bs   = step_seen;
        br   = rev_seen;
        prev = 4'b0000;
        for (int s = 0; s < 150; s++) begin
            int  len;
            int  tl;
            bit  glitch;
            if (s == 0) begin
                v = 4'b0000;
            end else begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 6) begin
                    tl = ($urandom_range(0, 1) == 1) ? m_level + 1 : m_level - 1;
                    if (tl < 0) tl = 1;
                    if (tl > 4) tl = 3;
                    v = 4'((1 << tl) - 1);
                end else if (r < 8) begin
                    v = 4'($urandom_range(0, 15));
                end else begin
                    tl = int'($urandom_range(0, 4));
                    v = 4'((1 << tl) - 1);
                end
                if (v == prev) v = ~v;
            end
            glitch = (s > 0) && ($urandom_range(0, 4) == 0);
            len = glitch ? int'($urandom_range(1, STABLE - 1))
                         : int'($urandom_range(STABLE + 3, STABLE + 8));
            in = v;
            repeat (len) @(negedge clk);
            if (!glitch) begin
                model_accept(v);
                chk_outs($sformatf("rand%0d", s), m_level, m_valid, m_dir, m_err, m_cnt);
                chk($sformatf("rand%0d.steps", s), 32'(step_seen - bs), 32'(m_steps));
                chk($sformatf("rand%0d.revs", s), 32'(rev_seen - br), 32'(m_revs));
            end
            prev = v;
        end

        chk("reverse_without_step", 32'(lone_rev), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
